// File: rtl/cbus_mem_responder.sv
// Cache-bus responder: word-addressed scratch memory serving single and burst
// reads/writes, with a fixed number of idle cycles before the first beat.

package cbus_pkg;

  typedef enum logic [2:0] {
    CSZ_BYTE = 3'd0,
    CSZ_HALF = 3'd1,
    CSZ_WORD = 3'd2
  } cbus_size_e;

  // Burst length encodings: beats = len + 1
  localparam logic [3:0] MLEN1 = 4'd0;
  localparam logic [3:0] MLEN2 = 4'd1;
  localparam logic [3:0] MLEN4 = 4'd3;
  localparam logic [3:0] MLEN8 = 4'd7;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    cbus_size_e  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

module cbus_mem_responder
  import cbus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned LATENCY    = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);

  localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  LAT_LAST = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BURST
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            lat_cnt_q, lat_cnt_d;
  logic [3:0]            beat_q, beat_d;
  logic [3:0]            len_q, len_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  wr_q, wr_d;

  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic                  in_burst;
  logic                  mem_we;

  // Request fields this responder never looks at (size, byte offset, high address bits)
  logic unused_req_bits;
  assign unused_req_bits = ^{creq.size, creq.addr[31:ADDR_WIDTH+2], creq.addr[1:0]};

  // NOTE: sequential state uses non-blocking assignments only; all next-state
  // logic lives in the always_comb below.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      lat_cnt_q <= '0;
      beat_q    <= '0;
      len_q     <= '0;
      base_q    <= '0;
      wr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      beat_q    <= beat_d;
      len_q     <= len_d;
      base_q    <= base_d;
      wr_q      <= wr_d;
    end
  end

  // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    beat_d    = beat_q;
    len_d     = len_q;
    base_d    = base_q;
    wr_d      = wr_q;

    unique case (state_q)
      S_IDLE: begin
        beat_d    = '0;
        lat_cnt_d = '0;
        if (creq.valid) begin
          wr_d    = creq.is_write;
          len_d   = creq.len;
          base_d  = creq.addr[ADDR_WIDTH+1:2];
          state_d = (LATENCY > 0) ? S_WAIT : S_BURST;
        end
      end

      S_WAIT: begin
        if (!creq.valid) begin
          state_d = S_IDLE;
        end else if (lat_cnt_q == LAT_LAST) begin
          state_d = S_BURST;
        end else begin
          lat_cnt_d = lat_cnt_q + 4'd1;
        end
      end

      S_BURST: begin
        // Dropping valid aborts; earlier beats stay written
        if (!creq.valid || (beat_q == len_q)) begin
          state_d = S_IDLE;
        end else begin
          beat_d = beat_q + 4'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Base plus beat index truncated to ADDR_WIDTH bits, so bursts wrap at the top
  assign in_burst  = (state_q == S_BURST);
  assign beat_addr = base_q + ADDR_WIDTH'(beat_q);
  assign mem_we    = in_burst && wr_q && creq.valid;

  // NOTE: the memory array has no reset; contents survive resetn by design.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (creq.strobe[i]) begin
          mem[beat_addr][8*i +: 8] <= creq.data[8*i +: 8];
        end
      end
    end
  end

  // Outputs decode registered state only, never creq.valid
  always_comb begin
    cresp       = '0;
    cresp.ready = in_burst;
    cresp.last  = in_burst && (beat_q == len_q);
    if (in_burst && !wr_q) begin
      cresp.data = mem[beat_addr];
    end
  end

endmodule

// File: tb/tb_cbus_mem_responder.sv
// Bench for cbus_mem_responder: two instances (latency 2 and 0), a reference
// memory model and a queue of expected beats checked as the DUT produces them.

module tb_cbus_mem_responder;
  import cbus_pkg::*;

  localparam int AW = 12;
  localparam int N  = 2 ** AW;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetn;
  cbus_req_t  req, req_a, req_b;
  cbus_resp_t resp, resp_a, resp_b;
  int         sel = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        exp_q[$];
  logic [31:0] model [int];
  logic [31:0] wdat [16];
  logic [3:0]  wstb [16];

  assign req_a = (sel == 0) ? req : '0;
  assign req_b = (sel == 1) ? req : '0;
  assign resp  = (sel == 1) ? resp_b : resp_a;

  cbus_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(2)) dut_l2 (
    .clk    (clk),
    .resetn (resetn),
    .creq   (req_a),
    .cresp  (resp_a)
  );

  cbus_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(0)) dut_l0 (
    .clk    (clk),
    .resetn (resetn),
    .creq   (req_b),
    .cresp  (resp_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int key(input int s, input int w);
    return s * N + w;
  endfunction

  // Scoreboard side: every handshaked beat pops one expectation
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && resp.ready && req.valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 32'(resp.ready), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("beat_cycle", 32'(cyc), 32'(e.cyc));
        check("beat_data", resp.data, e.data);
        check("beat_last", 32'(resp.last), 32'(e.last));
      end
    end
  end

  // Called at posedge+1 with the selected DUT idle in this cycle
  task automatic burst(input int s, input bit wr, input logic [31:0] addr,
                       input int nbeats, input int abort_after, input bit hold);
    int          lat, a, bi, w, k;
    logic [31:0] d;
    logic [AW-1:0] base;
    bit          r, l, done;

    lat = (s == 0) ? 2 : 0;
    sel = s;
    req.valid    = 1'b1;
    req.is_write = wr;
    req.addr     = addr;
    req.len      = 4'(nbeats - 1);
    req.size     = cbus_size_e'(3'($urandom_range(0, 2)));
    req.data     = wdat[0];
    req.strobe   = wstb[0];
    a    = cyc;
    base = addr[AW+1:2];

    for (int b = 0; b < nbeats; b++) begin
      if (abort_after >= 0 && b >= abort_after) break;
      w = (int'(base) + b) % N;
      k = key(s, w);
      if (wr) begin
        d = model.exists(k) ? model[k] : 32'h0;
        for (int i = 0; i < 4; i++)
          if (wstb[b][i]) d[8*i +: 8] = wdat[b][8*i +: 8];
        model[k] = d;
        d = 32'h0;
      end else begin
        d = model[k];
      end
      exp_q.push_back('{cyc: a + 1 + lat + b, data: d, last: (b == nbeats - 1)});
    end

    bi   = 0;
    done = 1'b0;
    for (int t = 0; t < 40 && !done; t++) begin
      req.data   = wdat[bi];
      req.strobe = wstb[bi];
      if (abort_after >= 0 && bi == abort_after) begin
        req.valid = 1'b0;
        @(posedge clk); #1;
        check("abort_idle", 32'(resp.ready), 32'd0);
        done = 1'b1;
      end else begin
        r = resp.ready;
        l = resp.last;
        @(posedge clk); #1;
        if (r) begin
          if (bi < 15) bi++;
          if (l) begin
            done = 1'b1;
            if (!hold) req.valid = 1'b0;
            check("post_idle", 32'(resp.ready), 32'd0);
          end
        end
      end
    end

    check("burst_done", 32'(done), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    if (!done) begin
      req.valid = 1'b0;
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    req    = '0;
    for (int i = 0; i < 16; i++) begin
      wdat[i] = 32'h0;
      wstb[i] = 4'hF;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready_l2", 32'(resp_a.ready), 32'd0);
    check("rst_last_l2", 32'(resp_a.last), 32'd0);
    check("rst_data_l2", resp_a.data, 32'd0);
    check("rst_ready_l0", 32'(resp_b.ready), 32'd0);
    check("rst_last_l0", 32'(resp_b.last), 32'd0);
    check("rst_data_l0", resp_b.data, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Read burst over preloaded words 0x100..0x103
    for (int i = 0; i < 4; i++) wdat[i] = 32'h11111111 * (i + 1);
    burst(0, 1'b1, 32'h0000_0400, 4, -1, 1'b0);
    burst(0, 1'b0, 32'h0000_0400, 4, -1, 1'b0);

    // Write burst with a partial-strobe beat over an all-ones word
    wdat[0] = 32'hFFFF_FFFF;
    burst(0, 1'b1, 32'h0000_0418, 1, -1, 1'b0);
    for (int i = 0; i < 4; i++) wdat[i] = 32'hA0 + i;
    wstb[2] = 4'b0101;
    burst(0, 1'b1, 32'h0000_0410, 4, -1, 1'b0);
    wstb[2] = 4'hF;
    burst(0, 1'b0, 32'h0000_0410, 4, -1, 1'b0);

    // Eight-beat burst
    for (int i = 0; i < 8; i++) wdat[i] = 32'h8000_0000 | (i * 32'h0101);
    burst(0, 1'b1, 32'h0000_0600, 8, -1, 1'b0);
    burst(0, 1'b0, 32'h0000_0600, 8, -1, 1'b0);

    // Zero-latency single-beat byte write on word 2
    wdat[0] = 32'h1234_5678;
    burst(1, 1'b1, 32'h0000_0008, 1, -1, 1'b0);
    wdat[0] = 32'h0000_BB00;
    wstb[0] = 4'b0010;
    burst(1, 1'b1, 32'h0000_0008, 1, -1, 1'b0);
    wstb[0] = 4'hF;
    burst(1, 1'b0, 32'h0000_0008, 1, -1, 1'b0);
    wdat[0] = 32'hCAFE_0001;
    wdat[1] = 32'hCAFE_0002;
    burst(1, 1'b1, 32'h0000_0010, 2, -1, 1'b0);
    burst(1, 1'b0, 32'h0000_0010, 2, -1, 1'b0);

    // Wrap at the top of memory
    for (int i = 0; i < 4; i++) wdat[i] = 32'h5A5A_0000 + i;
    burst(0, 1'b1, 32'h0000_3FF8, 4, -1, 1'b0);
    burst(0, 1'b0, 32'h0000_3FF8, 4, -1, 1'b0);
    burst(0, 1'b0, 32'h0000_0000, 2, -1, 1'b0);

    // Abort after two beats of a write burst
    for (int i = 0; i < 4; i++) wdat[i] = 32'hC0C0_C0C0 + i;
    burst(0, 1'b1, 32'h0000_0500, 4, -1, 1'b0);
    for (int i = 0; i < 4; i++) wdat[i] = 32'hD0D0_D0D0 + i;
    burst(0, 1'b1, 32'h0000_0500, 4, 2, 1'b0);
    burst(0, 1'b0, 32'h0000_0500, 4, -1, 1'b0);

    // Back-to-back reads with valid held through the last beat
    burst(0, 1'b0, 32'h0000_0400, 4, -1, 1'b1);
    burst(0, 1'b0, 32'h0000_0410, 4, -1, 1'b0);

    // Asynchronous reset in the middle of a read burst
    mon_en       = 1'b0;
    sel          = 0;
    req.valid    = 1'b1;
    req.is_write = 1'b0;
    req.addr     = 32'h0000_0400;
    req.len      = MLEN4;
    for (int t = 0; t < 20 && !resp.ready; t++) begin
      @(posedge clk); #1;
    end
    check("rst_reached_burst", 32'(resp.ready), 32'd1);
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    check("async_rst_ready", 32'(resp_a.ready), 32'd0);
    check("async_rst_last", 32'(resp_a.last), 32'd0);
    check("async_rst_data", resp_a.data, 32'd0);
    req.valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_ready", 32'(resp_a.ready), 32'd0);
    mon_en = 1'b1;
    burst(0, 1'b0, 32'h0000_0400, 4, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
